// File: rtl/first_n_clusters_pkg.sv
// Shared constants, width helper and candidate record for the first-N cluster finder.
package first_n_clusters_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_NPART = 4;
  localparam int DEF_PARTW = 384;
  localparam int DEF_NPASS = 4;
  localparam int DEF_NOUT  = 8;
  localparam int DEF_CNTW  = 3;
  localparam int DEF_ADRW  = clog2(DEF_NPART * DEF_PARTW);

  // Candidate record at the default geometry; the top re-declares it at its own widths.
  typedef struct packed {
    logic [DEF_ADRW-1:0] adr;
    logic [DEF_CNTW-1:0] cnt;
    logic                vld;
  } cand_t;

endpackage

// File: rtl/first_n_clusters_priority_encoder_part.sv
// Lowest-set-bit encoder for one partition: local address, size of that pad,
// found flag and the input with that bit cleared (next working mask).
module priority_encoder_part
  import first_n_clusters_pkg::*;
#(
  parameter  int PARTW = DEF_PARTW,
  parameter  int CNTW  = DEF_CNTW,
  localparam int LADRW = clog2(PARTW)
) (
  input  logic [PARTW-1:0]      i_vpf,
  input  logic [PARTW*CNTW-1:0] i_cnt,
  output logic [LADRW-1:0]      o_adr,
  output logic [CNTW-1:0]       o_cnt,
  output logic                  o_found,
  output logic [PARTW-1:0]      o_rest
);

  // Scan high to low so the last hit written is the lowest set pad.
  always_comb begin
    o_adr = '0;
    o_cnt = '0;
    for (int i = PARTW - 1; i >= 0; i--) begin
      if (i_vpf[i]) begin
        o_adr = LADRW'(i);
        o_cnt = i_cnt[i*CNTW +: CNTW];
      end
    end
  end

  assign o_found = |i_vpf;
  // x & (x-1) clears exactly the lowest set bit.
  assign o_rest  = i_vpf & (i_vpf - PARTW'(1));

endmodule

// File: rtl/first_n_clusters.sv
// Multi-pass per-partition priority encoding followed by an address-ordered
// compaction that reports the first NOUT clusters of each frame.
module first_n_clusters
  import first_n_clusters_pkg::*;
#(
  parameter  int NPART = DEF_NPART,
  parameter  int PARTW = DEF_PARTW,
  parameter  int NPASS = DEF_NPASS,
  parameter  int NOUT  = DEF_NOUT,
  parameter  int CNTW  = DEF_CNTW,
  localparam int ADRW  = clog2(NPART * PARTW)
) (
  input  logic                        clock4x,
  input  logic                        reset,
  input  logic                        frame_clock,
  input  logic [NPART*PARTW-1:0]      vpfs_in,
  input  logic [NPART*PARTW*CNTW-1:0] cnts_in,
  output logic [NOUT*ADRW-1:0]        adr_out,
  output logic [NOUT*CNTW-1:0]        cnt_out,
  output logic [NOUT-1:0]             vld_out,
  output logic                        frame_valid,
  output logic                        overflow
);

  localparam int LADRW = clog2(PARTW);
  localparam int PW    = clog2(NPASS);
  localparam int NC    = NPART * NPASS;
  localparam int CW    = clog2(NC + 1);

  typedef struct packed {
    logic [ADRW-1:0] adr;
    logic [CNTW-1:0] cnt;
    logic            vld;
  } slot_t;

  logic             r_fclk_d, r_busy, r_trunc, r_ovf;
  logic [PW-1:0]    r_pass;
  logic [1:0]       r_vld_pipe;   // [0]: merge register loaded, [1]: outputs loaded
  logic [PARTW-1:0] r_mask [NPART];
  slot_t            r_slot [NPART][NPASS-1];
  slot_t            r_cand [NC];

  logic             w_start, w_run, w_last, w_trunc, w_ovf;
  logic [PW-1:0]    w_pidx;
  logic [CW-1:0]    w_total;
  logic [PARTW-1:0] w_enc_in [NPART];
  logic [PARTW-1:0] w_rest   [NPART];
  slot_t            w_live   [NPART];

  assign w_start = frame_clock & ~r_fclk_d;
  assign w_run   = w_start | r_busy;
  // A new start in the last pass aborts that frame, so no snapshot then.
  assign w_last  = r_busy & ~w_start & (r_pass == PW'(NPASS - 1));
  assign w_pidx  = w_start ? '0 : r_pass;

  for (genvar gp = 0; gp < NPART; gp++) begin : g_part
    logic [LADRW-1:0] w_ladr;
    logic [CNTW-1:0]  w_lcnt;
    logic             w_found;

    assign w_enc_in[gp] = w_start ? vpfs_in[gp*PARTW +: PARTW] : r_mask[gp];

    priority_encoder_part #(.PARTW(PARTW), .CNTW(CNTW)) u_enc (
      .i_vpf   (w_enc_in[gp]),
      .i_cnt   (cnts_in[gp*PARTW*CNTW +: PARTW*CNTW]),
      .o_adr   (w_ladr),
      .o_cnt   (w_lcnt),
      .o_found (w_found),
      .o_rest  (w_rest[gp])
    );

    assign w_live[gp] = {ADRW'(gp * PARTW) + ADRW'(w_ladr), w_lcnt, w_found};
  end

  // Pads left over after the last pass mean per-partition truncation.
  always_comb begin
    w_trunc = 1'b0;
    for (int p = 0; p < NPART; p++) w_trunc = w_trunc | (|w_rest[p]);
  end

  // Edge detect, pass sequencing, working masks and the output-valid pipe.
  always_ff @(posedge clock4x) begin
    if (reset) begin
      r_fclk_d   <= 1'b0;
      r_busy     <= 1'b0;
      r_pass     <= '0;
      r_vld_pipe <= '0;
      r_ovf      <= 1'b0;
      for (int p = 0; p < NPART; p++) r_mask[p] <= '0;
    end else begin
      r_fclk_d   <= frame_clock;
      r_vld_pipe <= {r_vld_pipe[0], w_last};
      if (w_start) begin
        r_busy <= 1'b1;
        r_pass <= PW'(1);
      end else if (w_last) begin
        r_busy <= 1'b0;
        r_pass <= '0;
      end else if (r_busy) begin
        r_pass <= r_pass + PW'(1);
      end
      if (w_run)
        for (int p = 0; p < NPART; p++) r_mask[p] <= w_rest[p];
      if (r_vld_pipe[0]) r_ovf <= w_ovf;
    end
  end

  // Per-pass result slots; last pass is taken live into the merge register.
  always_ff @(posedge clock4x) begin
    for (int p = 0; p < NPART; p++) begin
      for (int q = 0; q < NPASS - 1; q++)
        if (w_run && w_pidx == PW'(q)) r_slot[p][q] <= w_live[p];
      if (w_last) begin
        for (int q = 0; q < NPASS - 1; q++) r_cand[p*NPASS + q] <= r_slot[p][q];
        r_cand[p*NPASS + NPASS - 1] <= w_live[p];
      end
    end
    if (w_last) r_trunc <= w_trunc;
  end

  // Total found across all candidates, for the count-overflow condition.
  always_comb begin
    w_total = '0;
    for (int i = 0; i < NC; i++) w_total = w_total + CW'(r_cand[i].vld);
    w_ovf = (w_total > CW'(NOUT)) | r_trunc;
  end

  // Output k selects the candidate whose prefix count of valid entries equals k.
  for (genvar gk = 0; gk < NOUT; gk++) begin : g_out
    slot_t         w_sel, r_out;
    logic [CW-1:0] w_n;

    // Walk candidates in address order counting hits until the k-th.
    always_comb begin
      w_sel = '0;
      w_n   = '0;
      for (int i = 0; i < NC; i++) begin
        if (r_cand[i].vld) begin
          if (w_n == CW'(gk)) w_sel = r_cand[i];
          w_n = w_n + CW'(1);
        end
      end
    end

    // Output register, held between frames.
    always_ff @(posedge clock4x) begin
      if (reset)              r_out <= '0;
      else if (r_vld_pipe[0]) r_out <= w_sel;
    end

    assign adr_out[gk*ADRW +: ADRW] = r_out.adr;
    assign cnt_out[gk*CNTW +: CNTW] = r_out.cnt;
    assign vld_out[gk]              = r_out.vld;
  end

  assign frame_valid = r_vld_pipe[1];
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_first_n_clusters.sv
// Directed bench: frame-level reference model plus literal expectations.
module tb_first_n_clusters;
  import first_n_clusters_pkg::*;

  localparam int NPART = 4, PARTW = 384, NPASS = 4, NOUT = 8, CNTW = 3;
  localparam int NPADS = NPART * PARTW;
  localparam int ADRW  = clog2(NPADS);

  logic                    clock4x = 1'b0, reset = 1'b1, frame_clock = 1'b0;
  logic [NPADS-1:0]        vpfs_in = '0;
  logic [NPADS*CNTW-1:0]   cnts_in = '0;
  logic [NOUT*ADRW-1:0]    adr_out;
  logic [NOUT*CNTW-1:0]    cnt_out;
  logic [NOUT-1:0]         vld_out;
  logic                    frame_valid, overflow;

  first_n_clusters #(.NPART(NPART), .PARTW(PARTW), .NPASS(NPASS), .NOUT(NOUT), .CNTW(CNTW)) dut (
    .clock4x(clock4x), .reset(reset), .frame_clock(frame_clock),
    .vpfs_in(vpfs_in), .cnts_in(cnts_in),
    .adr_out(adr_out), .cnt_out(cnt_out), .vld_out(vld_out),
    .frame_valid(frame_valid), .overflow(overflow)
  );

  always #5 clock4x = ~clock4x;

  typedef struct {
    int                   start;
    int                   done;
    logic [NOUT*ADRW-1:0] adr;
    logic [NOUT*CNTW-1:0] cnt;
    logic [NOUT-1:0]      vld;
    logic                 ovf;
  } res_t;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: up to NPASS lowest pads per partition, concatenated in address order.
  function automatic res_t model(input logic [NPADS-1:0] v, input logic [NPADS*CNTW-1:0] c);
    res_t r;
    int   pc [NPART];
    int   n, p;
    bit   tr;
    r.adr = '0; r.cnt = '0; r.vld = '0; r.start = 0; r.done = 0;
    n = 0; tr = 0;
    for (int i = 0; i < NPART; i++) pc[i] = 0;
    for (int g = 0; g < NPADS; g++) begin
      if (v[g]) begin
        p = g / PARTW;
        if (pc[p] < NPASS) begin
          pc[p]++;
          if (n < NOUT) begin
            r.adr[n*ADRW +: ADRW] = ADRW'(g);
            r.cnt[n*CNTW +: CNTW] = c[g*CNTW +: CNTW];
            r.vld[n] = 1'b1;
          end
          n++;
        end else tr = 1;
      end
    end
    r.ovf = (n > NOUT) || tr;
    return r;
  endfunction

  // Per-cycle frame model and output compare.
  bit   en = 0, m_prev = 0, m_start;
  int   cyc = 0;
  res_t q[$];
  res_t exp_r, m_r;
  logic exp_fv = 1'b0;

  always begin
    @(posedge clock4x);
    if (reset) begin
      en = 1; q.delete(); m_prev = 0; exp_fv = 1'b0;
      exp_r.adr = '0; exp_r.cnt = '0; exp_r.vld = '0; exp_r.ovf = 1'b0;
    end else if (en) begin
      m_start = frame_clock && !m_prev;
      m_prev  = frame_clock;
      exp_fv  = 1'b0;
      if (m_start) begin
        while (q.size() > 0 && (cyc - q[q.size()-1].start) < NPASS) q.pop_back();
        m_r = model(vpfs_in, cnts_in);
        m_r.start = cyc; m_r.done = cyc + NPASS + 1;
        q.push_back(m_r);
      end
      if (q.size() > 0 && q[0].done == cyc + 1) begin
        exp_r = q[0]; exp_fv = 1'b1;
        void'(q.pop_front());
      end
    end
    cyc++;
    #1;
    if (en) begin
      chk("cyc_frame_valid", 128'(frame_valid), 128'(exp_fv));
      chk("cyc_vld_out",     128'(vld_out),     128'(exp_r.vld));
      chk("cyc_adr_out",     128'(adr_out),     128'(exp_r.adr));
      chk("cyc_cnt_out",     128'(cnt_out),     128'(exp_r.cnt));
      chk("cyc_overflow",    128'(overflow),    128'(exp_r.ovf));
    end
  end

  // Stimulus helpers: inputs change at negedge; the following posedge samples them.
  logic [NPADS-1:0]      nv;
  logic [NPADS*CNTW-1:0] nc;
  int fv_seen = 0;

  task automatic clear_pads(); nv = '0; nc = '0; endtask
  task automatic set_pad(input int i, input int c);
    nv[i] = 1'b1; nc[i*CNTW +: CNTW] = CNTW'(c);
  endtask
  task automatic tick(input logic fc, input logic rst);
    @(negedge clock4x); frame_clock = fc; reset = rst;
    if (frame_valid) fv_seen++;
  endtask
  task automatic frame_start();
    @(negedge clock4x); vpfs_in = nv; cnts_in = nc; frame_clock = 1'b1; reset = 1'b0;
    if (frame_valid) fv_seen++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask
  function automatic logic [ADRW-1:0] adr_k(input int k); return adr_out[k*ADRW +: ADRW]; endfunction
  function automatic logic [CNTW-1:0] cnt_k(input int k); return cnt_out[k*CNTW +: CNTW]; endfunction

  res_t pin;
  int   base;

  initial begin
    tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0);
    chk("rst_frame_valid", 128'(frame_valid), 0);
    chk("rst_vld_out",     128'(vld_out), 0);
    chk("rst_overflow",    128'(overflow), 0);
    chk("rst_adr_out",     128'(adr_out), 0);
    chk("rst_cnt_out",     128'(cnt_out), 0);

    // Pin the model on the 12-cluster pattern.
    clear_pads();
    for (int p = 0; p < NPART; p++) for (int j = 1; j <= 3; j++) set_pad(p*PARTW + 10*j, 2);
    pin = model(nv, nc);
    chk("model_c12_adr7", 128'(pin.adr[7*ADRW +: ADRW]), 788);
    chk("model_c12_adr3", 128'(pin.adr[3*ADRW +: ADRW]), 394);
    chk("model_c12_vld",  128'(pin.vld), 8'hFF);
    chk("model_c12_ovf",  128'(pin.ovf), 1);

    // Reset at S+2 discards the frame.
    clear_pads(); set_pad(5, 3); set_pad(1000, 1);
    base = fv_seen;
    frame_start(); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0);
      chk("rstmid_vld", 128'(vld_out), 0);
    end
    chk("rstmid_no_fv", 128'(fv_seen - base), 0);

    // Two sparse pads.
    frame_start(); idle(5);
    chk("a_fv",   128'(frame_valid), 1);
    chk("a_vld",  128'(vld_out), 8'b00000011);
    chk("a_adr0", 128'(adr_k(0)), 5);
    chk("a_cnt0", 128'(cnt_k(0)), 3);
    chk("a_adr1", 128'(adr_k(1)), 1000);
    chk("a_cnt1", 128'(cnt_k(1)), 1);
    chk("a_ovf",  128'(overflow), 0);

    // Five pads in partition 1: truncated to four.
    clear_pads(); for (int i = 0; i < 5; i++) set_pad(384 + i, i + 1);
    frame_start(); idle(5);
    chk("t_vld",  128'(vld_out), 8'b00001111);
    chk("t_adr0", 128'(adr_k(0)), 384);
    chk("t_adr3", 128'(adr_k(3)), 387);
    chk("t_cnt3", 128'(cnt_k(3)), 4);
    chk("t_ovf",  128'(overflow), 1);

    // Twelve clusters over four partitions.
    clear_pads();
    for (int p = 0; p < NPART; p++) for (int j = 1; j <= 3; j++) set_pad(p*PARTW + 10*j, p + 1);
    frame_start(); idle(5);
    chk("c12_vld",  128'(vld_out), 8'hFF);
    chk("c12_adr2", 128'(adr_k(2)), 30);
    chk("c12_adr5", 128'(adr_k(5)), 414);
    chk("c12_adr7", 128'(adr_k(7)), 788);
    chk("c12_cnt7", 128'(cnt_k(7)), 3);
    chk("c12_ovf",  128'(overflow), 1);

    // Back-to-back frames every NPASS cycles.
    base = fv_seen;
    clear_pads(); set_pad(0, 7); set_pad(1535, 6);
    frame_start(); idle(3);
    clear_pads(); set_pad(383, 1); set_pad(384, 2); set_pad(767, 3); set_pad(768, 4);
    frame_start(); idle(3);
    clear_pads(); for (int i = 1; i <= 5; i++) set_pad(i, i);
    frame_start(); idle(6);
    chk("b2b_fv_count", 128'(fv_seen - base), 3);
    chk("b2b_vld",  128'(vld_out), 8'b00001111);
    chk("b2b_adr0", 128'(adr_k(0)), 1);
    chk("b2b_adr3", 128'(adr_k(3)), 4);
    chk("b2b_ovf",  128'(overflow), 1);

    // Empty frame, then a start aborted by another two cycles later.
    clear_pads();
    frame_start(); idle(5);
    chk("e_fv",  128'(frame_valid), 1);
    chk("e_vld", 128'(vld_out), 0);
    chk("e_ovf", 128'(overflow), 0);
    base = fv_seen;
    clear_pads(); set_pad(7, 7);
    frame_start(); tick(1'b0, 1'b0);
    clear_pads(); set_pad(100, 5); set_pad(1200, 2);
    frame_start(); idle(6);
    chk("ab_fv_count", 128'(fv_seen - base), 1);
    chk("ab_vld",  128'(vld_out), 8'b00000011);
    chk("ab_adr0", 128'(adr_k(0)), 100);
    chk("ab_cnt0", 128'(cnt_k(0)), 5);
    chk("ab_adr1", 128'(adr_k(1)), 1200);
    chk("ab_cnt1", 128'(cnt_k(1)), 2);

    // frame_clock held high then low: no new frame, outputs hold.
    base = fv_seen;
    clear_pads(); set_pad(3, 1);
    frame_start();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    idle(8);
    chk("hold_fv_count", 128'(fv_seen - base), 1);
    chk("hold_adr0",     128'(adr_k(0)), 3);
    chk("hold_vld",      128'(vld_out), 8'b00000001);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/first_n_clusters.md
Name: first_n_clusters

Overview:
- Parametrised successor to the fixed 1536-pad, 2-partition, first-8 cluster finder.
- Splits NPART*PARTW valid-pad flags into NPART partitions. Each pass, every partition priority-encodes its lowest set pad, latches it and clears it, for NPASS passes per frame.
- Compacts the NPART*NPASS candidates in global address order and outputs the first NOUT, with valid flags and an overflow flag.
- Sits between the cluster finder (vpf/cnt per pad) and the cluster packer/formatter.

Parameters:
- NPART, 4, number of partitions encoded in parallel (>=1).
- PARTW, 384, pads per partition.
- NPASS, 4, encoder passes per frame, i.e. candidates per partition (>=2).
- NOUT, 8, clusters reported per frame (<= NPART*NPASS).
- CNTW, 3, cluster-size field width.
- ADRW, clog2(NPART*PARTW), global address width (derived, not overridable).

Ports:
- clock4x  in  1  fast clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_clock  in  1  frame clock, sampled in clock4x domain.
- vpfs_in  in  NPART*PARTW  per-pad cluster-valid flags; stable on frame-start cycle.
- cnts_in  in  NPART*PARTW*CNTW  per-pad cluster size; pad i at [i*CNTW +: CNTW]; stable for the whole frame.
- adr_out  out  NOUT*ADRW  cluster k global address at [k*ADRW +: ADRW].
- cnt_out  out  NOUT*CNTW  cluster k size.
- vld_out  out  NOUT  cluster k valid.
- frame_valid  out  1  one-cycle strobe: outputs updated this cycle.
- overflow  out  1  clusters were dropped this frame.

Behaviour:
- Reset: all outputs 0, pass counter idle, working masks 0, edge-detect register 0. Any frame in progress is discarded; no frame_valid for it.
- Frame start S: the clock4x cycle where frame_clock is sampled 1 and was sampled 0 the previous cycle.
- Pass p (cycle S+p, p=0..NPASS-1):
  - p=0 encodes directly from vpfs_in; later passes encode the working mask.
  - Each partition outputs local address of its lowest set bit, cnts_in at that pad, and a found flag.
  - The found bit is cleared in the working mask; the result is stored in slot[part][p].
- Global address = part*PARTW + local, computed in ADRW bits; no wrap is possible.
- Snapshot at cycle S+NPASS-1: slots 0..NPASS-2 plus the live pass-(NPASS-1) encoder result are copied to the merge register. This is lookahead, so the next frame's pass 0 may start at S+NPASS.
- Merge (one registered stage):
  - Candidates are already in address order: part0 slot0..slotNPASS-1, then part1, and so on.
  - Output k = k-th found candidate.
  - Outputs with no candidate: adr 0, cnt 0, vld 0.
- Latency: outputs and frame_valid=1 during cycle S+NPASS+1. Outputs hold until the next frame_valid.
- overflow=1 (registered with frame_valid) if either:
  - total found > NOUT, or
  - any partition mask is still non-zero after the last pass (per-partition truncation).
- Frame starts closer than NPASS cycles apart: the in-progress frame is aborted (no frame_valid) and the new frame starts at pass 0.
- Empty frame: frame_valid still pulses, vld_out=0, overflow=0.
- frame_clock held high or low: no new frame; outputs hold.

Decomposition:
- Shared package first_n_clusters_pkg:
  - clog2 function.
  - Candidate struct/constants {adr, cnt, vld} sized from ADRW/CNTW.
  - Default parameter constants.
- One sub-module, priority_encoder_part: PARTW-wide lowest-set-bit encoder with cnt mux and found flag. Combinational core; masking register in the parent.
- The compaction network stays in the parent as a generate-based prefix-count selector.

Test Plan:
- Reset mid-frame (assert at S+2, release) -> vld_out=0, frame_valid never pulses for that frame, next clean frame reports normally.
- Pads 5 (cnt 3) and 1000 (cnt 1) set, defaults -> at S+5: vld_out=8'b00000011, adr0=5, cnt0=3, adr1=1000, cnt1=1, overflow=0.
- 5 pads set in partition 1 (pads 384..388) -> first 4 reported as 384..387, vld_out=8'b00001111, overflow=1 (truncation).
- 3 pads in each of the 4 partitions (12 clusters) -> outputs are partition0's 3, partition1's 3, partition2's first 2 in ascending order, overflow=1.
- Back-to-back frames every 4 cycles with different patterns -> frame_valid every 4 cycles, each output set matches its own frame, no cross-frame mixing.
- Empty frame, then frame start after only 2 cycles -> empty frame gives frame_valid with vld_out=0; aborted frame gives no frame_valid; restarted frame reports correctly.
